classifier_seq_ctrl: RTL
========================

CLASSIFIER_SEQ_CTRL -- requirements
Module: classifier_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_FEATS, default 4, meaning features per class (2..255).
REQ-002 The block SHALL have parameter NUM_CLASSES, default 3, meaning class count (2..2^CLASS_BITS).
REQ-003 The block SHALL have parameter CLASS_BITS, default 3, meaning class index width.
REQ-004 The block SHALL have parameter ADDR_BITS, default 8, meaning address width of the feature and weight memories.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, declared as ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-high reset).
REQ-006 The block SHALL have the following control ports: start (in, 1, request one inference, sampled in IDLE only); busy (out, 1, high from start acceptance until done); done (out, 1, one-cycle completion pulse).
REQ-007 The block SHALL have the following memory ports: feat_addr (out, ADDR_BITS, feature read address); w_addr (out, ADDR_BITS, weight read address); rd_en (out, 1, read strobe, 1-cycle synchronous read latency); feat_data (in, signed 4, feature returned one cycle after rd_en); w_data (in, signed 8, weight returned one cycle after rd_en).
REQ-008 The block SHALL have the following datapath-facing ports: dp_clear (out, 1, one-cycle clear of MAC/argmax state); x_int4 (out, signed 4, feature to MAC); w_int8 (out, signed 8, weight to MAC); new_feat (out, 1, accumulate this cycle); new_class (out, 1, close current class, compare into argmax); class_id (out, CLASS_BITS, class being accumulated); max_class (in, CLASS_BITS, datapath argmax result); max_score (in, signed 20, datapath best score).
REQ-009 The block SHALL have the following result ports: result_class (out, CLASS_BITS, captured winner); result_score (out, signed 20, captured best score).

Function
REQ-010 The FSM SHALL have states IDLE, PRIME, STREAM, CLOSE, DRAIN, DONE.
REQ-011 In IDLE with start=1 at cycle T0, the block SHALL enter PRIME and set busy=1 from T0+1.
REQ-012 PRIME (T0+1) SHALL assert dp_clear=1 and rd_en=1 with feat_addr=0 and w_addr=0.
REQ-013 STREAM SHALL last NUM_FEATS cycles per class, and in cycle k (k=0..NUM_FEATS-1) of class c it SHALL drive new_feat=1, x_int4=feat_data, w_int8=w_data and class_id=c.
REQ-014 Read addresses SHALL be issued one cycle ahead of their consumption: feat_addr=f, w_addr=c*NUM_FEATS+f, rd_en=1 exactly one cycle before the matching new_feat cycle.
REQ-015 CLOSE SHALL follow each class's last STREAM cycle, lasting 1 cycle with new_class=1, new_feat=0, x_int4=0, w_int8=0 and class_id=c (held).
REQ-016 During CLOSE of a non-final class, rd_en=1 SHALL prefetch feat_addr=0 and w_addr=(c+1)*NUM_FEATS, and the FSM SHALL return to STREAM with class c+1.
REQ-017 After CLOSE of class NUM_CLASSES-1, the FSM SHALL go to DRAIN for 1 cycle with no strobes, waiting for the datapath argmax register update.
REQ-018 DONE SHALL last 1 cycle: done=1, result_class<=max_class and result_score<=max_score captured on that edge, busy=0 from the next cycle, then IDLE.
REQ-019 The stream SHALL be gapless: new_feat/new_class occupy cycles T0+2 .. T0+1+NUM_CLASSES*(NUM_FEATS+1); DRAIN is at T0+2+NUM_CLASSES*(NUM_FEATS+1) and done at T0+3+NUM_CLASSES*(NUM_FEATS+1).
REQ-020 new_feat and new_class SHALL never be high in the same cycle.
REQ-021 Whenever new_feat=0, x_int4 and w_int8 SHALL be 0.
REQ-022 rd_en SHALL be 0 outside PRIME, STREAM and CLOSE, and in the last STREAM cycle of the final class.
REQ-023 start SHALL be ignored while busy=1 (including the DONE cycle), with no restart and no effect on the sequence.
REQ-024 result_class and result_score SHALL hold their values until the next DONE.
REQ-025 Address arithmetic SHALL be unsigned ADDR_BITS wide; NUM_CLASSES*NUM_FEATS > 2^ADDR_BITS is a configuration error and out of scope.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE and drive busy=0, done=0, rd_en=0, dp_clear=0, new_feat=0, new_class=0, feat_addr=0, w_addr=0, x_int4=0, w_int8=0, class_id=0, result_class=0 and result_score=0.
REQ-027 If reset is asserted mid-sequence, the block SHALL abort with no done pulse and no result update, and the next start SHALL run a full sequence from PRIME.

Verification
REQ-028 Basic run: NUM_FEATS=4, NUM_CLASSES=3, features {5,3,1,0}, weights c0 {36,69,-127,-39}, c1 {21,-13,-5,-46}, c2 {-68,-48,88,81}, bench datapath attached -> stream matches REQ-013..REQ-016 cycle-for-cycle, done at T0+18, result_class=0, result_score=260.
REQ-029 Winner last: c2 weights replaced by {100,100,0,0} -> result_class=2, result_score=800; a second start immediately after done reruns with dp_clear, giving identical results.
REQ-030 Tie: c0 and c1 both score 61 -> result_class matches datapath max_class and is captured exactly on the done edge.
REQ-031 start pulsed at T0+5 and T0+17 -> ignored: single done, and busy is a continuous high pulse.
REQ-032 rst asserted at T0+9 for 1 cycle -> all outputs at reset values next cycle, no done, result regs 0; a subsequent start completes normally.
REQ-033 Protocol checker on all runs -> never new_feat & new_class together, x/w zero when new_feat=0, every w_addr in 0..NUM_CLASSES*NUM_FEATS-1.

Source files
------------

// File: rtl/classifier_seq_ctrl.sv
// classifier_seq_ctrl: sequences feature/weight reads into a MAC+argmax datapath, one class at a time,
// and captures the winning class and score when the stream completes.
module classifier_seq_ctrl #(
   parameter int NUM_FEATS   = 4,
   parameter int NUM_CLASSES = 3,
   parameter int CLASS_BITS  = 3,
   parameter int ADDR_BITS   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_BITS-1:0]  feat_addr,
   output logic [ADDR_BITS-1:0]  w_addr,
   output logic                  rd_en,
   input  logic signed [3:0]     feat_data,
   input  logic signed [7:0]     w_data,
   output logic                  dp_clear,
   output logic signed [3:0]     x_int4,
   output logic signed [7:0]     w_int8,
   output logic                  new_feat,
   output logic                  new_class,
   output logic [CLASS_BITS-1:0] class_id,
   input  logic [CLASS_BITS-1:0] max_class,
   input  logic signed [19:0]    max_score,
   output logic [CLASS_BITS-1:0] result_class,
   output logic signed [19:0]    result_score
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_PRIME  = 3'd1;
   localparam logic [2:0] S_STREAM = 3'd2;
   localparam logic [2:0] S_CLOSE  = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [ADDR_BITS-1:0]  NF_A   = ADDR_BITS'(NUM_FEATS);
   localparam logic [ADDR_BITS-1:0]  LAST_F = ADDR_BITS'(NUM_FEATS - 1);
   localparam logic [ADDR_BITS-1:0]  ONE_A  = ADDR_BITS'(1);
   localparam logic [CLASS_BITS-1:0] LAST_C = CLASS_BITS'(NUM_CLASSES - 1);
   localparam logic [CLASS_BITS-1:0] ONE_C  = CLASS_BITS'(1);

   logic [2:0]            state_q, state_d;
   logic [CLASS_BITS-1:0] cls_q, cls_d;
   logic [ADDR_BITS-1:0]  f_q, f_d;
   logic [ADDR_BITS-1:0]  wb_q, wb_d;
   logic [ADDR_BITS-1:0]  pre_f;
   logic                  prime, stream, close, last_f, last_c, fetch_f, fetch_c;

   assign prime   = state_q == S_PRIME;
   assign stream  = state_q == S_STREAM;
   assign close   = state_q == S_CLOSE;
   assign last_f  = f_q == LAST_F;
   assign last_c  = cls_q == LAST_C;
   assign pre_f   = f_q + ONE_A;
   // Reads run one cycle ahead: next feature inside a class, first feature of next class on CLOSE.
   assign fetch_f = stream && !last_f;
   assign fetch_c = close && !last_c;

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      f_d     = f_q;
      wb_d    = wb_q;
      case (state_q)
         S_IDLE:   state_d = start ? S_PRIME : S_IDLE;
         S_PRIME: begin
            state_d = S_STREAM;
            cls_d   = '0;
            f_d     = '0;
            wb_d    = '0;
         end
         S_STREAM: begin
            state_d = last_f ? S_CLOSE : S_STREAM;
            f_d     = last_f ? f_q : pre_f;
         end
         S_CLOSE: begin
            state_d = last_c ? S_DRAIN : S_STREAM;
            cls_d   = last_c ? cls_q : cls_q + ONE_C;
            f_d     = '0;
            wb_d    = last_c ? wb_q : wb_q + NF_A;
         end
         S_DRAIN:  state_d = S_DONE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign busy      = state_q != S_IDLE;
   assign done      = state_q == S_DONE;
   assign dp_clear  = prime;
   assign rd_en     = prime || fetch_f || fetch_c;
   assign feat_addr = fetch_f ? pre_f : '0;
   assign w_addr    = fetch_c ? wb_q + NF_A : fetch_f ? wb_q + pre_f : '0;
   assign new_feat  = stream;
   assign new_class = close;
   assign class_id  = (stream || close) ? cls_q : '0;
   assign x_int4    = stream ? feat_data : '0;
   assign w_int8    = stream ? w_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cls_q        <= '0;
         f_q          <= '0;
         wb_q         <= '0;
         result_class <= '0;
         result_score <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         f_q     <= f_d;
         wb_q    <= wb_d;
         if (done) begin
            result_class <= max_class;
            result_score <= max_score;
         end
      end
   end
endmodule
